fifo_read_ctrl_burst: RTL and testbench
=======================================

Name: fifo_read_ctrl_burst

Overview:
Parametrised read-side controller for the dual-clock packet FIFO, operating entirely in the read clock domain. It adds three things to plain single-word reads: fill-level reporting, almost-empty reporting, and an atomic burst mode that reads a whole packet of rlen words back-to-back. It takes the already-synchronised Gray write pointer and supplies the RAM read address and enable. It also drives the Gray read pointer that is sent back to the write domain.

Parameters:
PTR_SZ, 2, address width; FIFO depth = 2^PTR_SZ entries; pointers are PTR_SZ+1 bits.
AE_THRESH, 1, raempty asserts when fill level <= AE_THRESH; legal range 0..2^PTR_SZ.

Ports:
clk  in  1  read-domain clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-low reset.
rinc  in  1  level request for one word per cycle in IDLE.
rburst  in  1  one-cycle request to start a burst of rlen words.
rlen  in  PTR_SZ+1  burst length, sampled only with rburst.
rq2_waddr  in  PTR_SZ+1  Gray write pointer, already synchronised into clk.
raddr  out  PTR_SZ  RAM read address; equals rbin[PTR_SZ-1:0].
raddr_gray  out  PTR_SZ+1  registered Gray read pointer, returned to the write domain.
read_en  out  1  RAM read strobe; the word at raddr is consumed this cycle.
rempty  out  1  registered empty flag.
raempty  out  1  registered almost-empty flag.
rlevel  out  PTR_SZ+1  fill level = gray2bin(rq2_waddr) - rbin, mod 2^(PTR_SZ+1).
rbusy  out  1  high while in BURST.
rlast  out  1  high with the final read_en of a burst.
rerr  out  1  one-cycle pulse when a burst request is rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - rbin=0, raddr_gray=0, state=IDLE, burst counter=0.
  - Outputs: rempty=1, raempty=1, read_en=0, rbusy=0, rlast=0, rerr=0.
  - Reset asserted mid-burst aborts the burst immediately.
- Pointer:
  - rbin (PTR_SZ+1 bits) increments at the clock edge that ends every cycle with read_en=1.
  - rbin wraps modulo 2^(PTR_SZ+1); raddr therefore wraps from 2^PTR_SZ-1 to 0.
  - raddr_gray <= rbin_next ^ (rbin_next>>1), so it always equals Gray(rbin).
- rempty:
  - Registered: rempty <= (Gray(rbin_next) == rq2_waddr).
  - Deasserts one cycle after rq2_waddr advances.
  - Asserts in the cycle after the last word is read.
  - A stale rq2_waddr can only make the flag conservative, never optimistic.
- raempty: registered; raempty <= (gray2bin(rq2_waddr) - rbin_next) <= AE_THRESH.
- rlevel: combinational from registered rbin and the rq2_waddr input.
- FSM, two states, IDLE and BURST:
  - IDLE, rburst=1 (priority over rinc; no single read that cycle):
    - If rlen==0, rlen>2^PTR_SZ, or rlen>rlevel: rerr=1 for this cycle and stay IDLE.
    - Otherwise load cnt=rlen and go to BURST.
  - IDLE, rinc=1, rburst=0: read_en = !rempty, combinational in the same cycle. Reading when empty is impossible.
  - BURST:
    - read_en=1 and rbusy=1 every cycle; cnt decrements per cycle.
    - rlast=1 when cnt==1; the state returns to IDLE after that edge.
    - rinc and rburst are ignored in BURST.
    - Data availability is guaranteed because the write pointer never retreats.
- Latency:
  - Single read: read_en in the same cycle as rinc.
  - Burst: the first read_en comes in the cycle after rburst is sampled, followed by exactly rlen consecutive read_en cycles.
- rerr, rlast and read_en never assert while rst=0.

Test Plan:
- Reset (PTR_SZ=2): rst=0 with rinc=1 and rq2_waddr=2 -> raddr=0, raddr_gray=0, rempty=1, raempty=1, read_en=0.
- Single reads: release reset, rq2_waddr=2 (binary 3) -> rempty=0 after 1 cycle and rlevel=3. Hold rinc for 4 cycles -> read_en 1,1,1,0; raddr 0,1,2; raddr_gray ends at 2; rempty=1 after the 3rd read.
- Wrap: from rbin=3, rq2_waddr=5 (binary 6) and rinc held -> raddr 3,0,1; raddr_gray 6,7,5; rempty=1 at the end.
- Burst: rlevel=3, rburst=1 with rlen=3 and rinc toggling -> rerr=0; next 3 cycles read_en=1 and rbusy=1, rlast only on the 3rd; read_en=0 after; exactly 3 pointer increments.
- Reject and priority:
  - rlevel=2 with rlen=3 -> rerr pulse, no read_en, pointers unchanged.
  - rlen=0 -> rerr.
  - rinc=1 and rburst=1 together with a legal rlen -> no single read that cycle; the burst starts next cycle.
- Reset mid-burst: rst=0 in the 2nd burst cycle -> read_en, rbusy and rlast drop immediately; raddr=0, rempty=1. After release the FSM is in IDLE.

Source files
------------

// File: rtl/fifo_read_ctrl_burst.sv
// Read-side controller for the dual-clock packet FIFO (read clock domain).
// Keeps the binary/Gray read pointers and the empty / almost-empty flags,
// reports the fill level, and runs an atomic burst of rlen back-to-back reads.
module fifo_read_ctrl_burst #(
  parameter int PTR_SZ    = 2,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rinc,
  input  logic              rburst,
  input  logic [PTR_SZ:0]   rlen,
  input  logic [PTR_SZ:0]   rq2_waddr,
  output logic [PTR_SZ-1:0] raddr,
  output logic [PTR_SZ:0]   raddr_gray,
  output logic              read_en,
  output logic              rempty,
  output logic              raempty,
  output logic [PTR_SZ:0]   rlevel,
  output logic              rbusy,
  output logic              rlast,
  output logic              rerr
);

  localparam logic [PTR_SZ:0] DEPTH  = (PTR_SZ+1)'(2 ** PTR_SZ);
  localparam logic [PTR_SZ:0] AE_LVL = (PTR_SZ+1)'(AE_THRESH);
  localparam logic [PTR_SZ:0] ONE    = (PTR_SZ+1)'(1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [PTR_SZ:0]   rbin_q, rbin_d;
  logic [PTR_SZ:0]   cnt_q, cnt_d;
  logic [PTR_SZ:0]   raddr_gray_q, raddr_gray_d;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;

  logic [PTR_SZ:0]   wbin;
  logic [PTR_SZ:0]   lvl_next;
  logic              burst_bad;
  logic              ren_raw;
  logic              err_raw;
  logic              last_raw;

  // Gray-to-binary of the synchronised write pointer: bit i is the XOR of bits PTR_SZ..i.
  genvar gi;
  generate
    for (gi = 0; gi <= PTR_SZ; gi++) begin : g_g2b
      assign wbin[gi] = ^rq2_waddr[PTR_SZ:gi];
    end
  endgenerate

  // Next-state, strobes, level and flag logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ren_raw   = 1'b0;
    err_raw   = 1'b0;
    last_raw  = 1'b0;

    rlevel    = wbin - rbin_q;
    burst_bad = (rlen == '0) || (rlen > DEPTH) || (rlen > rlevel);

    case (state_q)
      IDLE: begin
        if (rburst) begin
          // A burst request takes priority; no single read is issued this cycle.
          if (burst_bad) begin
            err_raw = 1'b1;
          end else begin
            cnt_d   = rlen;
            state_d = BURST;
          end
        end else if (rinc) begin
          ren_raw = !rempty_q;
        end
      end
      BURST: begin
        // Availability of rlen words was checked on entry and the write
        // pointer never retreats, so every burst cycle reads.
        ren_raw = 1'b1;
        cnt_d   = cnt_q - ONE;
        if (cnt_q == ONE) begin
          last_raw = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are held low for the whole time reset is asserted.
    read_en = ren_raw & rst;
    rerr    = err_raw & rst;
    rlast   = last_raw & rst;

    rbin_d       = rbin_q + {{PTR_SZ{1'b0}}, read_en};
    raddr_gray_d = rbin_d ^ (rbin_d >> 1);
    lvl_next     = wbin - rbin_d;
    rempty_d     = (raddr_gray_d == rq2_waddr);
    raempty_d    = (lvl_next <= AE_LVL);
  end

  // State, pointer and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rbin_q       <= '0;
      raddr_gray_q <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rbin_q       <= rbin_d;
      raddr_gray_q <= raddr_gray_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
    end
  end

  assign raddr      = rbin_q[PTR_SZ-1:0];
  assign raddr_gray = raddr_gray_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rbusy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_read_ctrl_burst.sv
// Self-checking bench for fifo_read_ctrl_burst (PTR_SZ=2, AE_THRESH=1).
// A per-cycle vector table drives inputs and queues expected outputs;
// hand-written sequences cover mid-cycle asynchronous reset and a full-depth burst.
module tb_fifo_read_ctrl_burst;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         rinc;
  logic         rburst;
  logic [P:0]   rlen;
  logic [P:0]   rq2_waddr;
  logic [P-1:0] raddr;
  logic [P:0]   raddr_gray;
  logic         read_en, rempty, raempty, rbusy, rlast, rerr;
  logic [P:0]   rlevel;

  int checks = 0;
  int errors = 0;

  fifo_read_ctrl_burst #(.PTR_SZ(P), .AE_THRESH(1)) dut (
    .clk(clk), .rst(rst), .rinc(rinc), .rburst(rburst), .rlen(rlen),
    .rq2_waddr(rq2_waddr), .raddr(raddr), .raddr_gray(raddr_gray),
    .read_en(read_en), .rempty(rempty), .raempty(raempty), .rlevel(rlevel),
    .rbusy(rbusy), .rlast(rlast), .rerr(rerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, rinc, rburst;
    logic [P:0] rlen, wq;
    logic [P-1:0] raddr;
    logic [P:0] gray;
    logic       ren, e, ae;
    logic [P:0] lvl;
    logic       busy, last, err;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];
  vec_t sb [$];

  function automatic vec_t mk(int r, int i, int b, int l, int w, int a, int g,
                              int re, int e, int ae, int lv, int bu, int la, int er);
    vec_t v;
    v.rst = 1'(r); v.rinc = 1'(i); v.rburst = 1'(b);
    v.rlen = (P+1)'(l); v.wq = (P+1)'(w);
    v.raddr = P'(a); v.gray = (P+1)'(g);
    v.ren = 1'(re); v.e = 1'(e); v.ae = 1'(ae); v.lvl = (P+1)'(lv);
    v.busy = 1'(bu); v.last = 1'(la); v.err = 1'(er);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ex;
    int n_rd, n_last, last_at, cyc;

    //            rst inc bur len wq | raddr gray ren e ae lvl busy last err
    vt[0]  = mk(0, 1, 0, 0, 2,   0, 0, 0, 1, 1, 3, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 0, 2,   0, 0, 0, 1, 1, 3, 0, 0, 0);
    vt[2]  = mk(1, 0, 0, 0, 2,   0, 0, 0, 1, 1, 3, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 0, 2,   0, 0, 0, 0, 0, 3, 0, 0, 0);
    vt[4]  = mk(1, 1, 0, 0, 2,   0, 0, 1, 0, 0, 3, 0, 0, 0);
    vt[5]  = mk(1, 1, 0, 0, 2,   1, 1, 1, 0, 0, 2, 0, 0, 0);
    vt[6]  = mk(1, 1, 0, 0, 2,   2, 3, 1, 0, 1, 1, 0, 0, 0);
    vt[7]  = mk(1, 1, 0, 0, 2,   3, 2, 0, 1, 1, 0, 0, 0, 0);
    vt[8]  = mk(1, 1, 0, 0, 5,   3, 2, 0, 1, 1, 3, 0, 0, 0);
    vt[9]  = mk(1, 1, 0, 0, 5,   3, 2, 1, 0, 0, 3, 0, 0, 0);
    vt[10] = mk(1, 1, 0, 0, 5,   0, 6, 1, 0, 0, 2, 0, 0, 0);
    vt[11] = mk(1, 1, 0, 0, 5,   1, 7, 1, 0, 1, 1, 0, 0, 0);
    vt[12] = mk(1, 1, 0, 0, 5,   2, 5, 0, 1, 1, 0, 0, 0, 0);
    vt[13] = mk(1, 0, 0, 0, 1,   2, 5, 0, 1, 1, 3, 0, 0, 0);
    vt[14] = mk(1, 1, 1, 3, 1,   2, 5, 0, 0, 0, 3, 0, 0, 0);
    vt[15] = mk(1, 0, 0, 0, 1,   2, 5, 1, 0, 0, 3, 1, 0, 0);
    vt[16] = mk(1, 1, 1, 0, 1,   3, 4, 1, 0, 0, 2, 1, 0, 0);
    vt[17] = mk(1, 0, 0, 0, 1,   0, 0, 1, 0, 1, 1, 1, 1, 0);
    vt[18] = mk(1, 1, 0, 0, 1,   1, 1, 0, 1, 1, 0, 0, 0, 0);
    vt[19] = mk(1, 0, 0, 0, 2,   1, 1, 0, 1, 1, 2, 0, 0, 0);
    vt[20] = mk(1, 1, 1, 3, 2,   1, 1, 0, 0, 0, 2, 0, 0, 1);
    vt[21] = mk(1, 0, 1, 0, 2,   1, 1, 0, 0, 0, 2, 0, 0, 1);
    vt[22] = mk(1, 0, 1, 5, 2,   1, 1, 0, 0, 0, 2, 0, 0, 1);
    vt[23] = mk(1, 0, 0, 0, 2,   1, 1, 0, 0, 0, 2, 0, 0, 0);
    vt[24] = mk(1, 1, 1, 2, 2,   1, 1, 0, 0, 0, 2, 0, 0, 0);
    vt[25] = mk(1, 0, 0, 0, 2,   1, 1, 1, 0, 0, 2, 1, 0, 0);
    vt[26] = mk(0, 0, 0, 0, 2,   0, 0, 0, 1, 1, 3, 0, 0, 0);
    vt[27] = mk(1, 0, 0, 0, 2,   0, 0, 0, 1, 1, 3, 0, 0, 0);
    vt[28] = mk(1, 1, 0, 0, 2,   0, 0, 1, 0, 0, 3, 0, 0, 0);
    vt[29] = mk(1, 0, 0, 0, 2,   1, 1, 0, 0, 0, 2, 0, 0, 0);

    rst = 1'b0; rinc = 1'b1; rburst = 1'b0; rlen = '0; rq2_waddr = 3'd2;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      rst = vt[i].rst; rinc = vt[i].rinc; rburst = vt[i].rburst;
      rlen = vt[i].rlen; rq2_waddr = vt[i].wq;
      sb.push_back(vt[i]);
      @(negedge clk);
      ex = sb.pop_front();
      chk($sformatf("v%0d.raddr", i),      int'(raddr),      int'(ex.raddr));
      chk($sformatf("v%0d.raddr_gray", i), int'(raddr_gray), int'(ex.gray));
      chk($sformatf("v%0d.read_en", i),    int'(read_en),    int'(ex.ren));
      chk($sformatf("v%0d.rempty", i),     int'(rempty),     int'(ex.e));
      chk($sformatf("v%0d.raempty", i),    int'(raempty),    int'(ex.ae));
      chk($sformatf("v%0d.rlevel", i),     int'(rlevel),     int'(ex.lvl));
      chk($sformatf("v%0d.rbusy", i),      int'(rbusy),      int'(ex.busy));
      chk($sformatf("v%0d.rlast", i),      int'(rlast),      int'(ex.last));
      chk($sformatf("v%0d.rerr", i),       int'(rerr),       int'(ex.err));
      $display("vec %0d rst=%0b rinc=%0b rburst=%0b rlen=%0d wq=%0d -> raddr=%0d gray=%0d ren=%0b e=%0b ae=%0b lvl=%0d busy=%0b last=%0b err=%0b",
               i, rst, rinc, rburst, rlen, rq2_waddr, raddr, raddr_gray, read_en,
               rempty, raempty, rlevel, rbusy, rlast, rerr);
    end

    // Asynchronous reset asserted mid-cycle during a burst.
    @(posedge clk); #1;
    rinc = 1'b0; rburst = 1'b1; rlen = 3'd2;
    @(posedge clk); #1;
    rburst = 1'b0;
    #2;
    chk("midrst.pre_read_en", int'(read_en), 1);
    chk("midrst.pre_rbusy",   int'(rbusy),   1);
    #1 rst = 1'b0;
    #1;
    chk("midrst.read_en", int'(read_en), 0);
    chk("midrst.rbusy",   int'(rbusy),   0);
    chk("midrst.rlast",   int'(rlast),   0);
    chk("midrst.raddr",   int'(raddr),   0);
    chk("midrst.rempty",  int'(rempty),  1);
    $display("midrst read_en=%0b rbusy=%0b raddr=%0d rempty=%0b", read_en, rbusy, raddr, rempty);

    // Full-depth burst (rlen == 2^PTR_SZ) after reset release.
    @(posedge clk); #1;
    rst = 1'b1; rq2_waddr = 3'd6;
    @(posedge clk); #1;
    rburst = 1'b1; rlen = 3'd4;
    @(negedge clk);
    chk("full.rerr",   int'(rerr),   0);
    chk("full.rlevel", int'(rlevel), 4);
    chk("full.start_read_en", int'(read_en), 0);
    @(posedge clk); #1;
    rburst = 1'b0;
    n_rd = 0; n_last = 0; last_at = -1; cyc = 0;
    @(negedge clk);
    while (rbusy === 1'b1 && cyc < 20) begin
      n_rd += int'(read_en);
      if (rlast) begin
        n_last++;
        last_at = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    chk("full.no_timeout", int'(cyc < 20), 1);
    chk("full.reads",      n_rd,    4);
    chk("full.rlast_cnt",  n_last,  1);
    chk("full.rlast_pos",  last_at, 3);
    chk("full.raddr",      int'(raddr),      0);
    chk("full.raddr_gray", int'(raddr_gray), 6);
    chk("full.rempty",     int'(rempty),     1);
    chk("full.read_en",    int'(read_en),    0);
    $display("full burst reads=%0d rlast=%0d raddr=%0d gray=%0d rempty=%0b",
             n_rd, n_last, raddr, raddr_gray, rempty);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
